// File: rtl/register_bank_defs.sv
// Shared operation codes and flag bit positions for the register bank and the
// control sequencer that drives it.
package register_bank_defs;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_ASL  = 3'd4;
    localparam logic [2:0] OP_LSR  = 3'd5;
    localparam logic [2:0] OP_ROL  = 3'd6;
    localparam logic [2:0] OP_ROR  = 3'd7;

    localparam int FLAG_C     = 0;
    localparam int FLAG_Z     = 1;
    localparam int FLAG_N     = 2;
    localparam int FLAG_COUNT = 3;

endpackage

// File: rtl/register_op_unit.sv
// Combinational datapath for the single in-place operation applied to the
// addressed register; carry passes through untouched for LOAD/INC/DEC.
module register_op_unit
    import register_bank_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] in_i,
    input  logic             carry_in_i,
    input  logic             carry_cur_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_next_o,
    output logic             write_en_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result_o     = r_i;
        carry_next_o = carry_cur_i;
        write_en_o   = 1'b1;
        case (op_i)
            OP_HOLD: write_en_o = 1'b0;
            OP_LOAD: result_o = in_i;
            OP_INC:  result_o = r_i + WIDTH'(1);
            OP_DEC:  result_o = r_i - WIDTH'(1);
            OP_ASL: begin
                carry_next_o = r_i[WIDTH-1];
                result_o     = {r_i[WIDTH-2:0], 1'b0};
            end
            OP_LSR: begin
                carry_next_o = r_i[0];
                result_o     = {1'b0, r_i[WIDTH-1:1]};
            end
            OP_ROL: begin
                carry_next_o = r_i[WIDTH-1];
                result_o     = {r_i[WIDTH-2:0], carry_in_i};
            end
            OP_ROR: begin
                carry_next_o = r_i[0];
                result_o     = {carry_in_i, r_i[WIDTH-1:1]};
            end
            default: write_en_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank with two unbypassed combinational read ports,
// one operate-in-place write port and registered Z/N/C flags.
module register_bank
    import register_bank_defs::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic [2:0]        OP,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  IN,
    input  logic              CARRY_IN,
    input  logic [ADDR_W-1:0] RADDR_A,
    input  logic [ADDR_W-1:0] RADDR_B,
    output logic [WIDTH-1:0]  OUT_A,
    output logic [WIDTH-1:0]  OUT_B,
    output logic              CARRY_OUT,
    output logic              ZERO,
    output logic              NEG
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]      regs_q [DEPTH];
    logic [WIDTH-1:0]      regs_d [DEPTH];
    logic [FLAG_COUNT-1:0] flags_q;
    logic [FLAG_COUNT-1:0] flags_d;

    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] result;
    logic             carry_next;
    logic             write_en;
    logic             waddr_ok;

    assign waddr_ok = ({1'b0, WADDR} < DEPTH_L);

    // Address-decoded muxes: addresses with no matching register read as zero.
    always_comb begin
        r_cur = '0;
        OUT_A = '0;
        OUT_B = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (WADDR == ADDR_W'(i))   r_cur = regs_q[i];
            if (RADDR_A == ADDR_W'(i)) OUT_A = regs_q[i];
            if (RADDR_B == ADDR_W'(i)) OUT_B = regs_q[i];
        end
    end

    register_op_unit #(
        .WIDTH(WIDTH)
    ) u_op_unit (
        .op_i        (OP),
        .r_i         (r_cur),
        .in_i        (IN),
        .carry_in_i  (CARRY_IN),
        .carry_cur_i (flags_q[FLAG_C]),
        .result_o    (result),
        .carry_next_o(carry_next),
        .write_en_o  (write_en)
    );

    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        if (CE && waddr_ok && write_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WADDR == ADDR_W'(i)) regs_d[i] = result;
            end
            flags_d[FLAG_C] = carry_next;
            flags_d[FLAG_Z] = (result == '0);
            flags_d[FLAG_N] = result[WIDTH-1];
        end
    end

    // NOTE: the storage is a small flop array, not a RAM, so it takes the async reset
    // and OUT_x reads zero during reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    assign CARRY_OUT = flags_q[FLAG_C];
    assign ZERO      = flags_q[FLAG_Z];
    assign NEG       = flags_q[FLAG_N];

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench: a DEPTH=4 and a DEPTH=3 bank share stimulus; a reference
// model predicts each result, queued at drive time and checked after the edge.
module tb_register_bank;

    localparam int W = 8;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3;
    localparam logic [2:0] ASL  = 3'd4, LSR  = 3'd5, ROL = 3'd6, ROR = 3'd7;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         CE = 1'b0;
    logic [2:0]   OP = 3'd0;
    logic [1:0]   WADDR = 2'd0;
    logic [1:0]   RADDR_A = 2'd0;
    logic [1:0]   RADDR_B = 2'd0;
    logic [W-1:0] IN = '0;
    logic         CARRY_IN = 1'b0;

    logic [1:0][W-1:0] out_a;
    logic [1:0][W-1:0] out_b;
    logic [1:0]        c_o;
    logic [1:0]        z_o;
    logic [1:0]        n_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         d;
        logic [1:0] a;
        logic [7:0] val;
        logic       c;
        logic       z;
        logic       n;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_regs [2][4];
    logic       m_c [2];
    logic       m_z [2];
    logic       m_n [2];

    register_bank #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .CE(CE), .OP(OP), .WADDR(WADDR), .IN(IN),
        .CARRY_IN(CARRY_IN), .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
        .OUT_A(out_a[0]), .OUT_B(out_b[0]),
        .CARRY_OUT(c_o[0]), .ZERO(z_o[0]), .NEG(n_o[0])
    );

    register_bank #(.WIDTH(W), .DEPTH(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .CE(CE), .OP(OP), .WADDR(WADDR), .IN(IN),
        .CARRY_IN(CARRY_IN), .RADDR_A(RADDR_A), .RADDR_B(RADDR_B),
        .OUT_A(out_a[1]), .OUT_B(out_b[1]),
        .CARRY_OUT(c_o[1]), .ZERO(z_o[1]), .NEG(n_o[1])
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [7:0] model_read(input int d, input logic [1:0] a);
        return (int'(a) < depth_of(d)) ? m_regs[d][a] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) m_regs[d][i] = 8'h00;
            m_c[d] = 1'b0;
            m_z[d] = 1'b0;
            m_n[d] = 1'b0;
        end
    endtask

    // Predict the effect of the currently driven inputs on both banks and queue it.
    task automatic predict_push();
        for (int d = 0; d < 2; d++) begin
            logic [7:0] r;
            logic [7:0] res;
            logic       c;
            logic       we;
            exp_t       e;
            r   = model_read(d, WADDR);
            res = r;
            c   = m_c[d];
            we  = CE && (OP != HOLD) && (int'(WADDR) < depth_of(d));
            case (OP)
                LOAD: res = IN;
                INC:  res = r + 8'd1;
                DEC:  res = r - 8'd1;
                ASL:  begin c = r[7]; res = {r[6:0], 1'b0}; end
                LSR:  begin c = r[0]; res = {1'b0, r[7:1]}; end
                ROL:  begin c = r[7]; res = {r[6:0], CARRY_IN}; end
                ROR:  begin c = r[0]; res = {CARRY_IN, r[7:1]}; end
                default: res = r;
            endcase
            if (we) begin
                m_regs[d][WADDR] = res;
                m_c[d] = c;
                m_z[d] = (res == 8'h00);
                m_n[d] = res[7];
            end
            e.d   = d;
            e.a   = WADDR;
            e.val = model_read(d, WADDR);
            e.c   = m_c[d];
            e.z   = m_z[d];
            e.n   = m_n[d];
            sb.push_back(e);
        end
    endtask

    task automatic pop_check();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            RADDR_A = e.a;
            #0;
            check($sformatf("res%0d_a%0d", e.d, e.a), out_a[e.d], e.val);
            check($sformatf("c%0d", e.d), c_o[e.d], e.c);
            check($sformatf("z%0d", e.d), z_o[e.d], e.z);
            check($sformatf("n%0d", e.d), n_o[e.d], e.n);
        end
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic do_op(input logic ce, input logic [2:0] code, input logic [1:0] wa,
                         input logic [7:0] din, input logic cin);
        CE = ce; OP = code; WADDR = wa; IN = din; CARRY_IN = cin;
        RADDR_A = wa; RADDR_B = wa;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("pre_a%0d", d), out_a[d], model_read(d, wa));
            check($sformatf("pre_b%0d", d), out_b[d], model_read(d, wa));
        end
        predict_push();
        @(posedge CLK);
        #1;
        pop_check();
    endtask

    task automatic readback_all();
        for (int a = 0; a < 4; a++) begin
            RADDR_A = 2'(a);
            RADDR_B = 2'(3 - a);
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("rb_a%0d_%0d", d, a), out_a[d], model_read(d, 2'(a)));
                check($sformatf("rb_b%0d_%0d", d, 3 - a), out_b[d], model_read(d, 2'(3 - a)));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_a"}, out_a[d], 8'h00);
            check({tag, "_b"}, out_b[d], 8'h00);
            check({tag, "_flags"}, {c_o[d], z_o[d], n_o[d]}, 3'b000);
        end
    endtask

    initial begin
        model_reset();
        RADDR_A = 2'd1;
        RADDR_B = 2'd2;
        #2;
        check_reset_state("por");
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Reset mid-cycle with an enabled LOAD pending: the op is lost.
        do_op(1'b1, LOAD, 2'd1, 8'h5A, 1'b0);
        CE = 1'b1; OP = LOAD; WADDR = 2'd1; IN = 8'h77;
        RADDR_A = 2'd1; RADDR_B = 2'd1;
        @(negedge CLK);
        check("pre_rst", out_a[0], 8'h5A);
        #1 RST = 1'b1;
        #1;
        model_reset();
        check_reset_state("rst_async");
        @(posedge CLK);
        #1;
        check_reset_state("rst_edge");
        @(negedge CLK);
        RST = 1'b0;
        predict_push();
        @(posedge CLK);
        #1;
        pop_check();

        // Load and hold.
        do_op(1'b1, LOAD, 2'd2, 8'h80, 1'b0);
        do_op(1'b0, LOAD, 2'd2, 8'h11, 1'b0);
        do_op(1'b1, HOLD, 2'd2, 8'h11, 1'b0);

        // Wrap-around.
        do_op(1'b1, LOAD, 2'd3, 8'hFF, 1'b0);
        do_op(1'b1, INC,  2'd3, 8'h00, 1'b0);
        do_op(1'b1, DEC,  2'd3, 8'h00, 1'b0);
        do_op(1'b1, DEC,  2'd2, 8'h00, 1'b0);

        // Shift and rotate chain on reg0.
        do_op(1'b1, LOAD, 2'd0, 8'h81, 1'b0);
        do_op(1'b1, ASL,  2'd0, 8'h00, 1'b0);
        check("asl_val", out_a[0], 8'h02);
        do_op(1'b1, ROR,  2'd0, 8'h00, 1'b1);
        check("ror_val", out_a[0], 8'h81);
        do_op(1'b1, LSR,  2'd0, 8'h00, 1'b0);
        check("lsr_c", c_o[0], 1'b1);
        do_op(1'b1, ROL,  2'd0, 8'h00, 1'b1);
        check("rol_val", out_a[0], 8'h81);
        do_op(1'b1, INC,  2'd1, 8'h00, 1'b0);

        // Same-address read on both ports around a write.
        do_op(1'b1, LOAD, 2'd1, 8'h33, 1'b0);
        do_op(1'b1, LOAD, 2'd1, 8'h34, 1'b0);

        // Exhaustive load and readback on every register.
        for (int r = 0; r < 4; r++) begin
            for (int v = 0; v < 256; v++) begin
                do_op(1'b1, LOAD, 2'(r), 8'(v), 1'b0);
            end
        end

        // Out-of-range address on the DEPTH=3 bank.
        do_op(1'b1, LOAD, 2'd3, 8'hAA, 1'b0);
        readback_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
